// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_seq_mux2.sv
// Two-input word multiplexer used as the addend select of mult_seq.
module mux2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = sel ? d1 : d0;
    end

endmodule

// File: rtl/mult_seq.sv
// Sequential unsigned shift-add multiplier: one adder reused over WIDTH iterations.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mult_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned      CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    mult_state_t          r_state;
    mult_state_t          w_next;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_zero;
    logic                 w_step;

    assign w_zero = '0;

    mux2 #(
        .WIDTH (2 * WIDTH)
    ) u_addend_mux (
        .sel (r_mplier[0]),
        .d0  (w_zero),
        .d1  (r_mcand),
        .y   (w_addend)
    );

    // An iteration (add + shift + count) happens on every RUN edge, except the
    // early-exit edge that only retires the operation.
    always_comb begin
        w_step = (r_state == RUN);
`ifdef MULT_EARLY_EXIT_EN
        if (r_mplier == '0) begin
            w_step = 1'b0;
        end
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_next = DONE;
                end
`ifdef MULT_EARLY_EXIT_EN
                if (r_mplier == '0) begin
                    w_next = DONE;
                end
`endif
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
            if (r_state == IDLE && start) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, a};
                r_mplier <= b;
                r_cnt    <= '0;
            end else if (w_step) begin
                r_acc    <= r_acc + w_addend;
                r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: tb/tb_mult_seq.sv
// Directed, table-driven self-checking bench for mult_seq at WIDTH=8.
module tb_mult_seq;

    localparam int unsigned W = 8;
`ifdef MULT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk;
    logic           reset_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int unsigned n_checks;
    int unsigned n_pass;

    mult_seq #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        int unsigned    lat_full;
        int unsigned    lat_early;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse start with the given operands; report product at done, edges from
    // acceptance to done, and the number of cycles busy was seen high.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output logic [2*W-1:0] prod, output int unsigned lat,
                          output int unsigned busy_cnt);
        prod = '0;
        lat = 0;
        busy_cnt = 0;
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (busy) busy_cnt++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                prod = product;
                break;
            end
        end
    endtask

    initial begin
        logic [2*W-1:0] prod;
        int unsigned    lat;
        int unsigned    bcnt;
        int unsigned    exp_lat;
        int             pulse_t[$];
        int unsigned    late_done;

        n_checks = 0;
        n_pass   = 0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        reset_n  = 1'b0;

        vecs[0] = '{8'd13,  8'd11,  16'd143,   8, 5};
        vecs[1] = '{8'd255, 8'd255, 16'd65025, 8, 8};
        vecs[2] = '{8'd0,   8'd200, 16'd0,     8, 8};
        vecs[3] = '{8'd6,   8'd7,   16'd42,    8, 4};
        vecs[4] = '{8'd77,  8'd1,   16'd77,    8, 2};
        vecs[5] = '{8'd2,   8'h80,  16'd256,   8, 8};
        vecs[6] = '{8'd45,  8'd0,   16'd0,     8, 1};
        vecs[7] = '{8'd170, 8'd85,  16'd14450, 8, 8};
        vecs[8] = '{8'd255, 8'd1,   16'd255,   8, 2};
        vecs[9] = '{8'd1,   8'd128, 16'd128,   8, 8};

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_hold_product", product, 0);

        for (int i = 0; i < 10; i++) begin
            exp_lat = EARLY ? vecs[i].lat_early : vecs[i].lat_full;
            run_op(vecs[i].a, vecs[i].b, prod, lat, bcnt);
            check($sformatf("v%0d_product", i), prod, vecs[i].prod);
            check($sformatf("v%0d_latency", i), lat, exp_lat);
            check($sformatf("v%0d_busy_cycles", i), bcnt, exp_lat + 1);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), done, 0);
            check($sformatf("v%0d_busy_drop", i), busy, 0);
            check($sformatf("v%0d_product_hold", i), product, vecs[i].prod);
        end

        // Held start: back-to-back operations, spacing = latency + 2.
        exp_lat = EARLY ? 4 : 8;
        @(negedge clk);
        a = 8'd6;
        b = 8'd7;
        start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                pulse_t.push_back(c);
                check("held_product", product, 42);
            end
        end
        start = 1'b0;
        check("held_pulse_count", pulse_t.size(), EARLY ? 5 : 3);
        for (int p = 1; p < pulse_t.size(); p++) begin
            check("held_spacing", pulse_t[p] - pulse_t[p-1], exp_lat + 2);
        end
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        check("held_idle", busy, 0);

        // Operands change right after acceptance must not matter.
        @(negedge clk);
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 8'd3;
        b = 8'd3;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        check("late_change_product", product, 81);
        check("late_change_latency", lat, EARLY ? 5 : 8);

        // Asynchronous reset mid-RUN discards the operation.
        @(negedge clk);
        a = 8'd9;
        b = 8'd200;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_product", product, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        late_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        check("no_done_after_reset", late_done, 0);
        run_op(8'd5, 8'd5, prod, lat, bcnt);
        check("post_reset_product", prod, 25);
        check("post_reset_latency", lat, EARLY ? 4 : 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
